pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Program-counter / fetch-address generator for the IF stage. Drives pc_o and
//   ce_o straight into the instruction ROM's ce/addr inputs each cycle. Handles
//   sequential advance, branch redirect, pipeline stall, exception flush, and
//   branch requests that arrive while IF is stalled. Flags misaligned fetches and
//   keeps a fetch counter.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  first fetch address after reset release
//   STALL_W       6              width of pipeline stall vector (bit 0 = IF)
// PORTS
//   clk              in   1        clock, all state updates on posedge
//   rst              in   1        synchronous, active-low reset
//   stall            in   STALL_W  pipeline stall vector; only stall[0] used here
//   flush            in   1        exception flush from control unit
//   new_pc           in   32       exception handler / ERET target, valid with flush
//   branch_flag_i    in   1        branch/jump taken (from ID)
//   branch_target_i  in   32       branch/jump target, valid with branch_flag_i
//   pc_o             out  32       current fetch address (to inst ROM addr)
//   ce_o             out  1        fetch enable (to inst ROM ce), ChipEnable=1
//   fetch_misalign_o out  1        ce_o=1 and pc_o[1:0]!=2'b00 (combinational)
//   fetch_cnt_o      out  32       number of fetches issued since reset
// BEHAVIOUR
//   States: OFF (ce_o=0), RUN (ce_o=1, advancing), HOLD (ce_o=1, stall[0]=1).
//   Reset (rst=0 at posedge): ce_o=0, pc_o=RESET_VECTOR, fetch_cnt_o=0,
//     pending_valid=0, pending_pc=0. fetch_misalign_o=0. Reset wins over all.
//   OFF->RUN: first posedge with rst=1 sets ce_o=1; pc_o stays RESET_VECTOR, so
//     first ROM address is RESET_VECTOR, issued the cycle after reset release.
//     All other inputs ignored in that cycle.
//   With ce_o=1, priority at each posedge (highest first):
//     1 flush=1: pc_o<=new_pc; pending_valid<=0. Applies even if stall[0]=1.
//     2 stall[0]=1: pc_o holds. If branch_flag_i=1, pending_pc<=branch_target_i,
//       pending_valid<=1. A later branch during the same stall overwrites it.
//     3 branch_flag_i=1: pc_o<=branch_target_i; pending_valid<=0.
//     4 pending_valid=1: pc_o<=pending_pc; pending_valid<=0.
//     5 otherwise: pc_o<=pc_o+32'd4, wraps 32'hFFFF_FFFC->32'h0000_0000.
//   Redirect latency: target appears on pc_o the cycle after the request edge.
//     No bubble is inserted; delay-slot handling belongs to ID/IF-ID.
//   fetch_cnt_o: +1 at every posedge where ce_o=1 and stall[0]=0 and flush=0.
//     Wraps modulo 2^32. Does not count in OFF.
//   fetch_misalign_o: flag only, no redirect. pc_o keeps following the rules
//     above until flush. Misaligned addresses are passed to ROM unchanged.
//   Reset asserted mid-stall or with pending_valid=1: everything clears and the
//     OFF->RUN sequence runs again. No pending redirect survives reset.
//   stall[STALL_W-1:1] ignored. X on inputs while rst=0 must not propagate.
// TESTING
//   1 Reset 3 cyc then release -> ce_o=0 during reset; ce_o=1, pc_o=0 next cycle;
//     then 4, 8, 12; fetch_cnt_o=3 after pc_o reaches 12.
//   2 At pc_o=0x10, branch_flag_i=1, target=0x100 for 1 cyc -> pc_o=0x100, then
//     0x104.
//   3 At pc_o=0x20, stall[0]=1 for 3 cyc with branch at cycle 1 (target=0x200)
//     -> pc_o=0x20 held and fetch_cnt_o frozen; after stall drops, pc_o=0x200
//     then 0x204.
//   4 flush=1, new_pc=0x180, with stall[0]=1 and branch_flag_i=1 (target=0x300)
//     -> pc_o=0x180, pending cleared; next cycle 0x184 (not 0x300).
//   5 Branch target=0x102 -> fetch_misalign_o=1 while pc_o=0x102/0x106; flush to
//     0x180 -> fetch_misalign_o=0.
//   6 Force pc_o to 0xFFFF_FFFC via branch -> next pc_o=0x0. Reset during pending
//     stall -> pc_o=RESET_VECTOR; no later jump to pending target.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: sequential advance, branch redirect,
// stall with a deferred branch, exception flush, misalign flag and fetch counter.
//
//   state  | meaning
//   S_OFF  | in or just out of reset, ce_o=0, pc_o parked at RESET_VECTOR
//   S_RUN  | fetching, pc_o advances or redirects every cycle
//   S_HOLD | fetching but IF stalled, pc_o held, branches deferred
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_i,
    output logic [31:0]        pc_o,
    output logic               ce_o,
    output logic               fetch_misalign_o,
    output logic [31:0]        fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ce;
    logic [31:0] r_fetch_cnt;
    logic        r_pending_valid;
    logic [31:0] r_pending_pc;

    logic        w_stall_if;
    logic        w_unused_stall;

    assign w_stall_if     = stall[0];
    // Upper stall bits belong to later pipeline stages.
    assign w_unused_stall = &{1'b0, stall[STALL_W-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_OFF;
            r_pc            <= RESET_VECTOR;
            r_ce            <= 1'b0;
            r_fetch_cnt     <= 32'd0;
            r_pending_valid <= 1'b0;
            r_pending_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_state <= S_RUN;
                    r_ce    <= 1'b1;
                end
                default: begin
                    if (flush) begin
                        r_pc            <= new_pc;
                        r_pending_valid <= 1'b0;
                        r_state         <= S_RUN;
                    end else if (w_stall_if) begin
                        // Latest branch seen during the stall wins.
                        if (branch_flag_i) begin
                            r_pending_pc    <= branch_target_i;
                            r_pending_valid <= 1'b1;
                        end
                        r_state <= S_HOLD;
                    end else if (branch_flag_i) begin
                        r_pc            <= branch_target_i;
                        r_pending_valid <= 1'b0;
                        r_state         <= S_RUN;
                    end else if (r_pending_valid) begin
                        r_pc            <= r_pending_pc;
                        r_pending_valid <= 1'b0;
                        r_state         <= S_RUN;
                    end else begin
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_RUN;
                    end

                    if (!w_stall_if && !flush) begin
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    assign pc_o             = r_pc;
    assign ce_o             = r_ce;
    assign fetch_cnt_o      = r_fetch_cnt;
    assign fetch_misalign_o = r_ce & (r_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus pushes the expected post-edge outputs into a
// queue, a negedge monitor pops and compares them.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        fetch_misalign_o;
    logic [31:0] fetch_cnt_o;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    pc_gen #(.RESET_VECTOR(32'h0000_0000), .STALL_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .branch_flag_i    (branch_flag_i),
        .branch_target_i  (branch_target_i),
        .pc_o             (pc_o),
        .ce_o             (ce_o),
        .fetch_misalign_o (fetch_misalign_o),
        .fetch_cnt_o      (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pc_o !== e.pc || ce_o !== e.ce || fetch_misalign_o !== e.mis
                || fetch_cnt_o !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h ce=%b mis=%b cnt=%0d, want pc=%h ce=%b mis=%b cnt=%0d",
                         e.name, pc_o, ce_o, fetch_misalign_o, fetch_cnt_o,
                         e.pc, e.ce, e.mis, e.cnt);
            end
        end
    end

    task automatic cyc(input logic r, input logic st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt,
                       input logic [31:0] e_pc, input logic e_ce, input logic e_mis,
                       input logic [31:0] e_cnt, input string name);
        exp_t e;
        rst             = r;
        stall           = {5'b10101, st};
        flush           = fl;
        new_pc          = npc;
        branch_flag_i   = br;
        branch_target_i = tgt;
        @(posedge clk);
        #1;
        e.pc   = e_pc;
        e.ce   = e_ce;
        e.mis  = e_mis;
        e.cnt  = e_cnt;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_i = '0;
        @(posedge clk);
        #1;

        //  rst st fl new_pc        br tgt           pc            ce mis cnt
        cyc(0, 0, 0, 32'h0,        1, 32'h40,       32'h0,        0, 0, 0,  "reset0");
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0,  "reset1");
        cyc(0, 1, 1, 32'h88,       0, 32'h0,        32'h0,        0, 0, 0,  "reset2");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0,  "release");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 1,  "seq4");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 2,  "seq8");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'hC,        1, 0, 3,  "seq12");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h10,       1, 0, 4,  "seq16");
        cyc(1, 0, 0, 32'h0,        1, 32'h100,      32'h100,      1, 0, 5,  "branch100");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h104,      1, 0, 6,  "after_br");
        cyc(1, 0, 0, 32'h0,        1, 32'h20,       32'h20,       1, 0, 7,  "branch20");
        cyc(1, 1, 0, 32'h0,        1, 32'h200,      32'h20,       1, 0, 7,  "stall_br");
        cyc(1, 1, 0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 7,  "stall2");
        cyc(1, 1, 0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 7,  "stall3");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 0, 8,  "pending_apply");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h204,      1, 0, 9,  "after_pending");
        cyc(1, 1, 0, 32'h0,        1, 32'h300,      32'h204,      1, 0, 9,  "stall_br300");
        cyc(1, 1, 1, 32'h180,      1, 32'h300,      32'h180,      1, 0, 9,  "flush_stall");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h184,      1, 0, 10, "no_pending");
        cyc(1, 1, 0, 32'h0,        1, 32'h400,      32'h184,      1, 0, 10, "stall_br400");
        cyc(1, 1, 0, 32'h0,        1, 32'h500,      32'h184,      1, 0, 10, "stall_br500");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h500,      1, 0, 11, "overwrite");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h504,      1, 0, 12, "after_ow");
        cyc(1, 0, 0, 32'h0,        1, 32'h102,      32'h102,      1, 1, 13, "misalign1");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h106,      1, 1, 14, "misalign2");
        cyc(1, 0, 1, 32'h180,      0, 32'h0,        32'h180,      1, 0, 14, "flush_fix");
        cyc(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 15, "top_addr");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 16, "wrap");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 17, "after_wrap");
        cyc(1, 1, 0, 32'h0,        1, 32'h700,      32'h4,        1, 0, 17, "stall_br700");
        cyc(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0,  "reset_pend");
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0,  "reset_pend2");
        cyc(1, 0, 1, 32'h880,      1, 32'h900,      32'h0,        1, 0, 0,  "release2_ign");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 0, 1,  "no_stale1");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 0, 2,  "no_stale2");
        stim_done = 1;

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
